wb_periph_hub: RTL



---
 rtl/wb_periph_hub_if.sv | 44 ++++
 rtl/wb_periph_hub.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_periph_hub_if.sv
// Bus bundle between the Caravel Wishbone slave side and the peripheral ports of wb_periph_hub.
// Ports: wbs_* (Wishbone slave request/response), p_* (peripheral request/response, one-hot cyc/stb),
// p_irq_i / user_irq (interrupt requests in, aggregated interrupts out). slave = hub view, master = environment view.
interface wb_periph_hub_if #(
    parameter int NUM_PERIPH = 4,
    parameter int WIN_BITS   = 16,
    parameter int IRQ_W      = 3
);
    logic                       wbs_cyc_i;
    logic                       wbs_stb_i;
    logic                       wbs_we_i;
    logic [3:0]                 wbs_sel_i;
    logic [31:0]                wbs_adr_i;
    logic [31:0]                wbs_dat_i;
    logic                       wbs_ack_o;
    logic [31:0]                wbs_dat_o;

    logic [NUM_PERIPH-1:0]      p_cyc_o;
    logic [NUM_PERIPH-1:0]      p_stb_o;
    logic                       p_we_o;
    logic [3:0]                 p_sel_o;
    logic [WIN_BITS-1:0]        p_adr_o;
    logic [31:0]                p_dat_o;
    logic [32*NUM_PERIPH-1:0]   p_dat_i;
    logic [NUM_PERIPH-1:0]      p_ack_i;
    logic [NUM_PERIPH-1:0]      p_irq_i;
    logic [IRQ_W-1:0]           user_irq;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output p_cyc_o, p_stb_o, p_we_o, p_sel_o, p_adr_o, p_dat_o,
        input  p_dat_i, p_ack_i, p_irq_i,
        output user_irq
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  p_cyc_o, p_stb_o, p_we_o, p_sel_o, p_adr_o, p_dat_o,
        output p_dat_i, p_ack_i, p_irq_i,
        input  user_irq
    );
endinterface

// File: rtl/wb_periph_hub.sv
// Wishbone slave hub: decodes NUM_PERIPH equal windows plus a CSR window, forwards accesses, aggregates IRQs.
// Latency: request cycle to wbs_ack_o = 2 + peripheral ack delay; CSR/unmapped = 2; timeout = TIMEOUT_CYC + 2.
// Backpressure: one access in flight; a new request is only accepted in IDLE (never in the ack cycle).
// Ports: wb_clk_i/wb_rst_i (sync active-high reset), bus (wb_periph_hub_if.slave: wbs_*, p_*, p_irq_i, user_irq).
module wb_periph_hub #(
    parameter int          NUM_PERIPH  = 4,
    parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
    parameter int          WIN_BITS    = 16,
    parameter int          TIMEOUT_CYC = 255,
    parameter int          IRQ_W       = 3
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_periph_hub_if.slave bus
);
    localparam int          TMR_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0] ERR_DAT = 32'hDEAD_BEEF;

    // CSR doubles as the one-cycle local-response stage for unmapped accesses.
    typedef enum logic [1:0] {IDLE, WAIT, CSR, RESP} state_t;
    state_t state_q, state_d;

    logic [31:0]           rel_adr, win_idx;
    logic                  below_base, hit_periph, hit_csr;
    logic [NUM_PERIPH-1:0] dec_oh;

    logic [NUM_PERIPH-1:0] cyc_q;
    logic                  we_q, err_q, ack_q;
    logic [3:0]            sel_q;
    logic [WIN_BITS-1:0]   off_q;
    logic [31:0]           wdat_q, adr_q, rdat_q;
    logic [TMR_W-1:0]      tmr_q;

    logic [NUM_PERIPH-1:0] pend_q, mask_q, irq_q, irq_q2;
    logic [7:0]            to_cnt_q;
    logic [31:0]           last_err_q;
    logic [IRQ_W-1:0]      user_irq_q;

    logic                  accept, p_done, timed_out, aborted;
    logic [31:0]           p_rdat, csr_rdat;
    logic [NUM_PERIPH-1:0] wmask, pend_clr, irq_rise;
    logic                  csr_wr;
    logic [IRQ_W-1:0]      irq_vec;

    // Address decode. Addresses below the base wrap to a huge index and land in "unmapped".
    always_comb begin
        rel_adr    = bus.wbs_adr_i - ADDR_BASE;
        win_idx    = rel_adr >> WIN_BITS;
        below_base = bus.wbs_adr_i < ADDR_BASE;
        hit_periph = !below_base && (win_idx < 32'(NUM_PERIPH));
        hit_csr    = !below_base && (win_idx == 32'(NUM_PERIPH));
        dec_oh     = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            dec_oh[i] = (win_idx == 32'(i));
        end
    end

    // Next state and transition events. Master abort takes priority over a same-cycle peripheral ack.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        p_done    = 1'b0;
        timed_out = 1'b0;
        aborted   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                    accept  = 1'b1;
                    state_d = hit_periph ? WAIT : CSR;
                end
            end
            WAIT: begin
                if (!bus.wbs_cyc_i) begin
                    aborted = 1'b1;
                    state_d = IDLE;
                end else if (|(bus.p_ack_i & cyc_q)) begin
                    p_done  = 1'b1;
                    state_d = RESP;
                end else if (tmr_q == TMR_W'(TIMEOUT_CYC)) begin
                    timed_out = 1'b1;
                    state_d   = RESP;
                end
            end
            CSR:     state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Read-data mux, CSR read view, byte-enable mask and interrupt plumbing.
    always_comb begin
        p_rdat = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (cyc_q[i]) p_rdat = p_rdat | bus.p_dat_i[32*i +: 32];
        end
        case (off_q[3:0])
            4'h0:    csr_rdat = 32'(pend_q);
            4'h4:    csr_rdat = 32'(mask_q);
            4'h8:    csr_rdat = {24'd0, to_cnt_q};
            4'hC:    csr_rdat = last_err_q;
            default: csr_rdat = '0;
        endcase
        for (int i = 0; i < NUM_PERIPH; i++) begin
            wmask[i] = sel_q[i / 8];
        end
        csr_wr   = (state_q == CSR) && !err_q && we_q;
        pend_clr = (csr_wr && off_q[3:0] == 4'h0) ? (wdat_q[NUM_PERIPH-1:0] & wmask) : '0;
        irq_rise = irq_q & ~irq_q2;
        irq_vec  = '0;
        for (int j = 0; j < IRQ_W; j++) begin
            for (int i = 0; i < NUM_PERIPH; i++) begin
                if (i % IRQ_W == j) irq_vec[j] = irq_vec[j] | (pend_q[i] & mask_q[i]);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cyc_q      <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            sel_q      <= '0;
            off_q      <= '0;
            wdat_q     <= '0;
            adr_q      <= '0;
            rdat_q     <= '0;
            tmr_q      <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            irq_q      <= '0;
            irq_q2     <= '0;
            to_cnt_q   <= '0;
            last_err_q <= '0;
            user_irq_q <= '0;
        end else begin
            ack_q      <= 1'b0;
            irq_q      <= bus.p_irq_i;
            irq_q2     <= irq_q;
            user_irq_q <= irq_vec;
            // A new edge overrides a same-cycle W1C so no interrupt is lost.
            pend_q     <= (pend_q & ~pend_clr) | irq_rise;

            if (accept) begin
                we_q   <= bus.wbs_we_i;
                sel_q  <= bus.wbs_sel_i;
                off_q  <= rel_adr[WIN_BITS-1:0];
                wdat_q <= bus.wbs_dat_i;
                adr_q  <= bus.wbs_adr_i;
                err_q  <= !(hit_periph || hit_csr);
                cyc_q  <= hit_periph ? dec_oh : '0;
                tmr_q  <= '0;
            end

            if (state_q == WAIT) tmr_q <= tmr_q + TMR_W'(1);

            if (aborted) cyc_q <= '0;

            if (p_done) begin
                cyc_q  <= '0;
                ack_q  <= 1'b1;
                rdat_q <= we_q ? 32'd0 : p_rdat;
            end

            if (timed_out) begin
                cyc_q      <= '0;
                ack_q      <= 1'b1;
                rdat_q     <= ERR_DAT;
                last_err_q <= adr_q;
                if (to_cnt_q != 8'hFF) to_cnt_q <= to_cnt_q + 8'd1;
            end

            if (state_q == CSR) begin
                ack_q <= 1'b1;
                if (err_q) begin
                    rdat_q     <= ERR_DAT;
                    last_err_q <= adr_q;
                end else if (we_q) begin
                    rdat_q <= '0;
                    if (off_q[3:0] == 4'h4) mask_q <= (mask_q & ~wmask) | (wdat_q[NUM_PERIPH-1:0] & wmask);
                    if (off_q[3:0] == 4'h8) to_cnt_q <= '0;
                end else begin
                    rdat_q <= csr_rdat;
                end
            end
        end
    end

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = rdat_q;
    assign bus.p_cyc_o   = cyc_q;
    assign bus.p_stb_o   = cyc_q;
    assign bus.p_we_o    = we_q;
    assign bus.p_sel_o   = sel_q;
    assign bus.p_adr_o   = off_q;
    assign bus.p_dat_o   = wdat_q;
    assign bus.user_irq  = user_irq_q;
endmodule
